fifo_param: RTL and testbench

Parametrised, single-clock, valid/ready FIFO for buffet data staging. It generalises the team's basic FIFO in four ways:
- Depth may be any integer ≥ 2.
- Selectable first-word-fall-through (FWFT) or registered-output read mode.
- Occupancy, almost-full and almost-empty outputs, with configurable thresholds.
- Synchronous flush.

It sits between fill/drain engines and buffet storage, wherever rate decoupling with level feedback is required.

---
 rtl/fifo_param_pkg.sv | 16 +
 rtl/fifo_param_out_stage.sv | 40 ++++
 rtl/fifo_param.sv | 102 ++++++++++
 tb/tb_fifo_param.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_param_pkg.sv
// rtl/fifo_param_pkg.sv - shared constants and helpers for the parametrised FIFO
package fifo_param_pkg;

    localparam int FIFO_MODE_FWFT = 1;
    localparam int FIFO_MODE_REG  = 0;

    // Explicit compare keeps non-power-of-2 depths wrapping correctly.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/fifo_param_out_stage.sv
// rtl/fifo_param_out_stage.sv - registered head word and memory pop for the non-FWFT mode
module fifo_param_out_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic                  flush_i,
    input  logic                  mem_nempty,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  data_o_ready,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_o_valid,
    output logic                  out_v,
    output logic                  pop
);

    logic [DATA_WIDTH-1:0] out_q;
    logic                  rd_acc;

    assign data_o_valid = out_v & ~flush_i;
    assign rd_acc       = data_o_valid & data_o_ready;
    // Refill whenever the register is empty or is being drained this cycle.
    assign pop          = mem_nempty & ~flush_i & (~out_v | rd_acc);
    assign data_o       = out_q;

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            out_q <= '0;
            out_v <= 1'b0;
        end else if (flush_i) begin
            out_v <= 1'b0;
        end else if (pop) begin
            out_q <= mem_rdata;
            out_v <= 1'b1;
        end else if (rd_acc) begin
            out_v <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - single-clock valid/ready FIFO with level flags, flush and selectable read mode
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FWFT       = FIFO_MODE_FWFT,
    parameter int AF_LVL     = DEPTH - 1,
    parameter int AE_LVL     = 1,
    localparam int CW        = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_i_valid,
    output logic                  data_i_ready,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_o_valid,
    input  logic                  data_o_ready,
    output logic [CW-1:0]         occupancy_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         mem_cnt;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_nempty;
    logic                  wr_en;
    logic                  pop;
    logic                  out_v;

    assign mem_rdata    = mem[rd_ptr];
    assign mem_nempty   = (mem_cnt != '0);
    // A full memory refuses writes even when it is popped in the same cycle.
    assign data_i_ready = (mem_cnt != CNT_FULL) & ~flush_i;
    assign wr_en        = data_i_valid & data_i_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= PW'(ptr_inc(int'(wr_ptr), DEPTH));
            end
            if (pop) begin
                rd_ptr <= PW'(ptr_inc(int'(rd_ptr), DEPTH));
            end
            if (wr_en && !pop) begin
                mem_cnt <= mem_cnt + CW'(1);
            end else if (!wr_en && pop) begin
                mem_cnt <= mem_cnt - CW'(1);
            end
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign data_o       = mem_rdata;
        assign data_o_valid = mem_nempty & ~flush_i;
        assign out_v        = 1'b0;
        assign pop          = data_o_valid & data_o_ready;
    end else begin : g_reg
        fifo_param_out_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_out_stage (
            .clk         (clk),
            .nreset_i    (nreset_i),
            .flush_i     (flush_i),
            .mem_nempty  (mem_nempty),
            .mem_rdata   (mem_rdata),
            .data_o_ready(data_o_ready),
            .data_o      (data_o),
            .data_o_valid(data_o_valid),
            .out_v       (out_v),
            .pop         (pop)
        );
    end

    // Flags decode registered state only; no input reaches them combinationally.
    assign occupancy_o    = mem_cnt + CW'(out_v);
    assign almost_full_o  = int'(occupancy_o) >= AF_LVL;
    assign almost_empty_o = int'(occupancy_o) <= AE_LVL;

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed vector bench for fifo_param in both read modes
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [2:0] flush = '0, din_v = '0, dout_r = '0;
    logic [2:0] din_r, dout_v, af, ae;
    logic [7:0] din [3];
    logic [7:0] dout [3];
    logic [2:0] occ [3];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       irdy;
        logic       ov;
        logic [7:0] od;
        logic [2:0] occ;
        logic       af;
        logic       ae;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u_a (
        .clk(clk), .nreset_i(nreset), .flush_i(flush[0]), .data_i(din[0]),
        .data_i_valid(din_v[0]), .data_i_ready(din_r[0]), .data_o(dout[0]),
        .data_o_valid(dout_v[0]), .data_o_ready(dout_r[0]), .occupancy_o(occ[0]),
        .almost_full_o(af[0]), .almost_empty_o(ae[0]));

    fifo_param #(.DATA_WIDTH(8), .DEPTH(3), .FWFT(0)) u_b (
        .clk(clk), .nreset_i(nreset), .flush_i(flush[1]), .data_i(din[1]),
        .data_i_valid(din_v[1]), .data_i_ready(din_r[1]), .data_o(dout[1]),
        .data_o_valid(dout_v[1]), .data_o_ready(dout_r[1]), .occupancy_o(occ[1]),
        .almost_full_o(af[1]), .almost_empty_o(ae[1]));

    fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) u_c (
        .clk(clk), .nreset_i(nreset), .flush_i(flush[2]), .data_i(din[2]),
        .data_i_valid(din_v[2]), .data_i_ready(din_r[2]), .data_o(dout[2]),
        .data_o_valid(dout_v[2]), .data_o_ready(dout_r[2]), .occupancy_o(occ[2]),
        .almost_full_o(af[2]), .almost_empty_o(ae[2]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic wv, input logic [7:0] wd,
                         input logic rr, input logic fl);
        din_v[i]  = wv;
        din[i]    = wd;
        dout_r[i] = rr;
        flush[i]  = fl;
    endtask

    task automatic cyc(input int i, input logic wv, input logic [7:0] wd,
                       input logic rr, input logic fl);
        @(negedge clk);
        drive(i, wv, wd, rr, fl);
        #1;
    endtask

    initial begin
        int exp_occ;
        for (int i = 0; i < 3; i++) din[i] = '0;

        //          wv    wd     rr    irdy  ov    od     occ   af    ae
        tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h10, 3'd1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 8'h10, 3'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 8'h10, 3'd3, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 8'h10, 3'd5, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h10, 3'd5, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 3'd4, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 3'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 3'd2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h14, 3'd1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 8'h20, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h20, 3'd1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        nreset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_in_ready", i), din_r[i], 1);
            chk($sformatf("rst%0d_out_valid", i), dout_v[i], 0);
            chk($sformatf("rst%0d_occ", i), occ[i], 0);
            chk($sformatf("rst%0d_af", i), af[i], 0);
            chk($sformatf("rst%0d_ae", i), ae[i], 1);
        end
        chk("rst_reg_data", dout[1], 0);

        // Fill/drain, refused overfill and pointer wrap on DEPTH=5 FWFT
        for (int v = 0; v < 14; v++) begin
            cyc(0, tbl[v].wv, tbl[v].wd, tbl[v].rr, 1'b0);
            chk($sformatf("tbl%0d_in_ready", v), din_r[0], tbl[v].irdy);
            chk($sformatf("tbl%0d_valid", v), dout_v[0], tbl[v].ov);
            chk($sformatf("tbl%0d_occ", v), occ[0], tbl[v].occ);
            chk($sformatf("tbl%0d_af", v), af[0], tbl[v].af);
            chk($sformatf("tbl%0d_ae", v), ae[0], tbl[v].ae);
            if (tbl[v].ov) chk($sformatf("tbl%0d_data", v), dout[0], tbl[v].od);
        end

        // Streaming through DEPTH=3 registered-output FIFO
        for (int c = 0; c < 23; c++) begin
            cyc(1, c < 20, 8'(c + 1), 1'b1, 1'b0);
            exp_occ = (c == 0) ? 0 : (c == 1) ? 1 : (c <= 20) ? 2 : (c == 21) ? 1 : 0;
            chk($sformatf("stream%0d_occ", c), occ[1], exp_occ);
            chk($sformatf("stream%0d_valid", c), dout_v[1], int'(c >= 2 && c <= 21));
            if (c >= 2 && c <= 21) chk($sformatf("stream%0d_data", c), dout[1], c - 1);
            if (c < 20) chk($sformatf("stream%0d_in_ready", c), din_r[1], 1);
        end
        cyc(1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Full DEPTH=4 with simultaneous write and pop
        for (int k = 0; k < 4; k++) cyc(2, 1'b1, 8'(8'h31 + k), 1'b0, 1'b0);
        cyc(2, 1'b1, 8'h77, 1'b1, 1'b0);
        chk("fullpop_occ", occ[2], 4);
        chk("fullpop_in_ready", din_r[2], 0);
        chk("fullpop_af", af[2], 1);
        chk("fullpop_head", dout[2], 8'h31);
        for (int k = 0; k < 3; k++) begin
            cyc(2, 1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("fullpop_drain%0d_occ", k), occ[2], 3 - k);
            chk($sformatf("fullpop_drain%0d_in_ready", k), din_r[2], 1);
            chk($sformatf("fullpop_drain%0d_data", k), dout[2], 8'h32 + k);
        end
        cyc(2, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("fullpop_empty_valid", dout_v[2], 0);
        chk("fullpop_empty_occ", occ[2], 0);

        // Flush with three words held in the registered-output FIFO
        for (int k = 0; k < 3; k++) cyc(1, 1'b1, 8'(8'hC1 + k), 1'b0, 1'b0);
        cyc(1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_pre_occ", occ[1], 3);
        chk("flush_pre_head", dout[1], 8'hC1);
        chk("flush_pre_af", af[1], 1);
        cyc(1, 1'b1, 8'hEE, 1'b1, 1'b1);
        chk("flush_in_ready", din_r[1], 0);
        chk("flush_valid", dout_v[1], 0);
        cyc(1, 1'b1, 8'hAB, 1'b1, 1'b0);
        chk("flush_post_occ", occ[1], 0);
        chk("flush_post_ae", ae[1], 1);
        chk("flush_post_valid", dout_v[1], 0);
        cyc(1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_load_valid", dout_v[1], 0);
        chk("flush_load_occ", occ[1], 1);
        cyc(1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_first_valid", dout_v[1], 1);
        chk("flush_first_data", dout[1], 8'hAB);
        cyc(1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("flush_done_valid", dout_v[1], 0);

        // Backpressure: head held stable, order preserved
        for (int k = 0; k < 3; k++) cyc(1, 1'b1, 8'(8'hD1 + k), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, 1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("hold%0d_valid", k), dout_v[1], 1);
            chk($sformatf("hold%0d_data", k), dout[1], 8'hD1);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1'b0, 8'h00, 1'b1, 1'b0);
            chk($sformatf("hold_drain%0d_valid", k), dout_v[1], 1);
            chk($sformatf("hold_drain%0d_data", k), dout[1], 8'hD1 + k);
        end
        cyc(1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("hold_empty_valid", dout_v[1], 0);

        // Asynchronous reset between edges while busy
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(2, 1'b1, 8'(8'h41 + k), 1'b0, 1'b0);
            drive(1, k == 0, 8'h61, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(2, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("arst_pre_occ", occ[2], 4);
        chk("arst_pre_reg_data", dout[1], 8'h61);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_occ", occ[2], 0);
        chk("arst_in_ready", din_r[2], 1);
        chk("arst_valid", dout_v[2], 0);
        chk("arst_af", af[2], 0);
        chk("arst_ae", ae[2], 1);
        chk("arst_reg_valid", dout_v[1], 0);
        chk("arst_reg_data", dout[1], 0);
        @(negedge clk);
        nreset = 1'b1;
        cyc(2, 1'b1, 8'h5A, 1'b0, 1'b0);
        cyc(2, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("arst_after_valid", dout_v[2], 1);
        chk("arst_after_data", dout[2], 8'h5A);
        cyc(2, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("arst_after_empty", dout_v[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
